// File: rtl/direct_mapped_cache_if.sv
// rtl/direct_mapped_cache_if.sv - CPU request and RAM bus bundle for direct_mapped_cache
interface direct_mapped_cache_if #(
    parameter int ADDR_WIDTH = 14,
    parameter int DATA_WIDTH = 16
);
    logic                  cpu_req;
    logic                  cpu_we;
    logic [ADDR_WIDTH-1:0] cpu_addr;
    logic [DATA_WIDTH-1:0] cpu_wdata;
    logic [DATA_WIDTH-1:0] cpu_rdata;
    logic                  cpu_ready;
    logic                  cpu_hit;
    logic                  mem_cs;
    logic                  mem_we;
    logic                  mem_oe;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;

    // master is the CPU plus RAM environment, slave is the cache controller
    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
        input  cpu_rdata, cpu_ready, cpu_hit, mem_cs, mem_we, mem_oe, mem_addr, mem_wdata
    );
    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
        output cpu_rdata, cpu_ready, cpu_hit, mem_cs, mem_we, mem_oe, mem_addr, mem_wdata
    );
endinterface

// File: rtl/direct_mapped_cache.sv
// rtl/direct_mapped_cache.sv - direct-mapped write-through cache controller with hit/miss statistics
module direct_mapped_cache #(
    parameter int ADDR_WIDTH = 14,
    parameter int DATA_WIDTH = 16,
    parameter int INDEX_BITS = 4,
    parameter int MEM_LAT    = 1,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    direct_mapped_cache_if.slave bus,
    input  logic                 flush_i,
    input  logic                 stats_clr_i,
    output logic [CNT_WIDTH-1:0] hit_count_o,
    output logic [CNT_WIDTH-1:0] miss_count_o
);
    localparam int LINES    = 1 << INDEX_BITS;
    localparam int TAG_BITS = ADDR_WIDTH - INDEX_BITS;
    localparam int LAT_W    = $clog2(MEM_LAT + 1);

    typedef enum logic [1:0] {IDLE, MEM_RD, MEM_WR, DONE} state_t;

    state_t                  state_q;
    logic [LINES-1:0]        valid_q;
    logic [TAG_BITS-1:0]     tag_q  [LINES];
    logic [DATA_WIDTH-1:0]   data_q [LINES];
    logic [LAT_W-1:0]        lat_q;
    logic [DATA_WIDTH-1:0]   cpu_rdata_q;
    logic                    cpu_ready_q;
    logic                    cpu_hit_q;
    logic                    mem_cs_q;
    logic                    mem_we_q;
    logic                    mem_oe_q;
    logic [ADDR_WIDTH-1:0]   mem_addr_q;
    logic [DATA_WIDTH-1:0]   mem_wdata_q;
    logic [CNT_WIDTH-1:0]    hit_cnt_q;
    logic [CNT_WIDTH-1:0]    hit_cnt_d;
    logic [CNT_WIDTH-1:0]    miss_cnt_q;
    logic [CNT_WIDTH-1:0]    miss_cnt_d;

    logic [INDEX_BITS-1:0]   req_idx;
    logic [TAG_BITS-1:0]     req_tag;
    logic                    lookup_hit;
    logic                    accept;
    logic                    fill;
    logic                    line_we;
    logic [INDEX_BITS-1:0]   line_idx;
    logic [TAG_BITS-1:0]     line_tag;
    logic [DATA_WIDTH-1:0]   line_data;

    assign req_idx    = bus.cpu_addr[INDEX_BITS-1:0];
    assign req_tag    = bus.cpu_addr[ADDR_WIDTH-1:INDEX_BITS];
    assign lookup_hit = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    assign accept     = (state_q == IDLE) && !flush_i && bus.cpu_req;
    assign fill       = (state_q == MEM_RD) && (lat_q == '0);

    // Stores allocate at acceptance; load misses allocate when the RAM word arrives.
    // mem_addr_q still holds the latched miss address at fill time.
    assign line_we   = (accept && bus.cpu_we) || fill;
    assign line_idx  = fill ? mem_addr_q[INDEX_BITS-1:0] : req_idx;
    assign line_tag  = fill ? mem_addr_q[ADDR_WIDTH-1:INDEX_BITS] : req_tag;
    assign line_data = fill ? bus.mem_rdata : bus.cpu_wdata;

    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (stats_clr_i) begin
            hit_cnt_d  = '0;
            miss_cnt_d = '0;
        end else if (accept && !bus.cpu_we) begin
            if (lookup_hit) begin
                if (hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + 1'b1;
            end else if (miss_cnt_q != '1) begin
                miss_cnt_d = miss_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (line_we) begin
            tag_q[line_idx]  <= line_tag;
            data_q[line_idx] <= line_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            valid_q     <= '0;
            lat_q       <= '0;
            cpu_rdata_q <= '0;
            cpu_ready_q <= 1'b0;
            cpu_hit_q   <= 1'b0;
            mem_cs_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_oe_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            hit_cnt_q   <= '0;
            miss_cnt_q  <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
            if ((state_q == IDLE) && flush_i) begin
                valid_q <= '0;
            end else if (line_we) begin
                valid_q[line_idx] <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        cpu_hit_q  <= lookup_hit;
                        mem_addr_q <= bus.cpu_addr;
                        if (bus.cpu_we) begin
                            mem_cs_q    <= 1'b1;
                            mem_we_q    <= 1'b1;
                            mem_oe_q    <= 1'b0;
                            mem_wdata_q <= bus.cpu_wdata;
                            state_q     <= MEM_WR;
                        end else if (lookup_hit) begin
                            cpu_rdata_q <= data_q[req_idx];
                            cpu_ready_q <= 1'b1;
                            state_q     <= DONE;
                        end else begin
                            mem_cs_q <= 1'b1;
                            mem_oe_q <= 1'b1;
                            lat_q    <= LAT_W'(MEM_LAT);
                            state_q  <= MEM_RD;
                        end
                    end
                end
                MEM_RD: begin
                    // Controls span MEM_LAT cycles; the word is taken one edge after they drop
                    if (lat_q != '0) begin
                        lat_q <= lat_q - 1'b1;
                        if (lat_q == LAT_W'(1)) begin
                            mem_cs_q <= 1'b0;
                            mem_oe_q <= 1'b0;
                        end
                    end else begin
                        cpu_rdata_q <= bus.mem_rdata;
                        cpu_hit_q   <= 1'b0;
                        cpu_ready_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                MEM_WR: begin
                    mem_cs_q    <= 1'b0;
                    mem_we_q    <= 1'b0;
                    cpu_ready_q <= 1'b1;
                    state_q     <= DONE;
                end
                DONE: begin
                    cpu_ready_q <= 1'b0;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.cpu_rdata = cpu_rdata_q;
    assign bus.cpu_ready = cpu_ready_q;
    assign bus.cpu_hit   = cpu_hit_q;
    assign bus.mem_cs    = mem_cs_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_oe    = mem_oe_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign hit_count_o   = hit_cnt_q;
    assign miss_count_o  = miss_cnt_q;
endmodule

// File: doc/direct_mapped_cache.md
# direct_mapped_cache

Parametrised direct-mapped, write-through cache controller between the accumulator CPU's MAR/MBR datapath and the single-port synchronous RAM. It replaces the fixed single-entry cache with LINES = 2**INDEX_BITS one-word lines and a request/ready handshake on the CPU side. It also adds a registered memory-side bus with configurable read latency, a whole-cache flush, and saturating hit/miss statistics counters.

## Interface
- ADDR_WIDTH, 14, word address width; must be > INDEX_BITS
- DATA_WIDTH, 16, word width
- INDEX_BITS, 4, line index bits; LINES = 2**INDEX_BITS
- MEM_LAT, 1, RAM read latency in cycles, ≥1
- CNT_WIDTH, 16, statistics counter width
- clk  in  1  system clock; all state changes on the rising edge
- rst  in  1  asynchronous, active-high reset
- cpu_req  in  1  request valid; held until cpu_ready
- cpu_we  in  1  1 = store, 0 = load
- cpu_addr  in  ADDR_WIDTH  word address
- cpu_wdata  in  DATA_WIDTH  store data
- cpu_rdata  out  DATA_WIDTH  load data; valid while cpu_ready=1
- cpu_ready  out  1  one-cycle completion pulse
- cpu_hit  out  1  lookup result of the completing request; valid with cpu_ready
- flush  in  1  level; invalidates all lines
- stats_clr  in  1  synchronous clear of both counters
- mem_cs, mem_we, mem_oe  out  1  RAM controls
- mem_addr  out  ADDR_WIDTH  RAM address
- mem_wdata  out  DATA_WIDTH  RAM write data
- mem_rdata  in  DATA_WIDTH  RAM read data
- hit_count, miss_count  out  CNT_WIDTH  load hit and load miss counts

## Operation
- Address split: index = addr[INDEX_BITS-1:0]; tag = addr[ADDR_WIDTH-1:INDEX_BITS].
- Per line: valid bit, tag, and one data word.
- hit = valid[index] && tag[index] == tag(addr).
- Lookup uses cpu_addr at the accepting edge.
- States are IDLE, MEM_RD, MEM_WR and DONE. The request is latched on acceptance.
- IDLE, flush=1: clear all valid bits and stay in IDLE. Flush has priority over cpu_req. Flush is ignored outside IDLE; the requester holds it until the controller is in IDLE.
- IDLE, cpu_req=1, cpu_we=0, hit: load cpu_rdata from the line, set cpu_hit=1, increment hit_count, go to DONE.
- IDLE, cpu_req=1, cpu_we=0, miss: go to MEM_RD, drive mem_cs=1, mem_oe=1, mem_addr=addr, load the latency counter, increment miss_count.
- MEM_RD: hold the RAM controls. At the end of latency, sample mem_rdata, fill the line (valid=1, tag, data), set cpu_rdata, set cpu_hit=0, drop the RAM controls, go to DONE.
- IDLE, cpu_req=1, cpu_we=1 (write-through, write-allocate):
  - At the same edge, update the line (valid=1, tag, data=cpu_wdata).
  - Drive mem_cs=1, mem_we=1, mem_oe=0, mem_addr, mem_wdata.
  - cpu_hit captures the pre-update hit.
  - Go to MEM_WR. Stores do not change the counters.
- MEM_WR: after one cycle, drop the RAM controls and go to DONE.
- DONE: cpu_ready=1 for exactly this cycle, cpu_req is ignored, next state is IDLE.
- Counters saturate at all-ones. stats_clr zeros both counters. If stats_clr coincides with an increment, the counter reads 0. flush does not affect the counters.
- The line array has no reset requirement; only the valid bits are reset.

## Timing
- Reset values:
  - state = IDLE
  - cpu_ready, cpu_hit = 0; cpu_rdata = 0
  - mem_cs, mem_we, mem_oe = 0; mem_addr, mem_wdata = 0
  - counters = 0; all valid bits = 0
- All outputs are registered.
- Edge N is the edge that samples cpu_req in IDLE:
  - Load hit: cpu_ready is high from N to N+1.
  - Load miss: RAM controls are high from N to N+MEM_LAT; mem_rdata is sampled at N+1+MEM_LAT-1+1; cpu_ready is high for the following cycle. With MEM_LAT=1, ready is high from N+2 to N+3.
  - Store: mem_we is high from N to N+1; cpu_ready is high from N+1 to N+2.
- Back-to-back: the next request is sampled no earlier than one edge after DONE ends.
- rst mid-operation: all outputs drop asynchronously and any in-flight RAM write is aborted. No cpu_ready is issued. The lost request must be reissued.

## Test plan
- Reset, RAM[0x10B]=0x0005, load 0x10B → miss; mem_addr=0x10B for 1 cycle; cpu_ready 2 cycles after acceptance; cpu_rdata=0x0005, miss_count=1. Repeat the load → cpu_hit=1, ready next cycle, mem_cs stays 0, hit_count=1.
- Store 0x10D data 0x0023 → one cycle with mem_we=1, mem_addr=0x10D, mem_wdata=0x0023; cpu_hit=0. Then load 0x10D → hit returning 0x0023 with no RAM access.
- Conflict: load 0x10B, then load 0x20B (RAM 0x1234) → miss, rdata 0x1234. Then load 0x10B → miss again; miss_count=3.
- Flush held for one cycle in IDLE after hits → next load 0x10B misses; hit_count and miss_count unchanged by the flush. A simultaneous flush and cpu_req → flush first, and the request is accepted on the following edge.
- Assert rst during MEM_RD (MEM_LAT=3) → mem_cs and mem_oe drop immediately, no cpu_ready, all lines invalid, counters 0.
- CNT_WIDTH=4: 17 load hits → hit_count=0xF. stats_clr coinciding with a hit → 0.
